skid_buffer: RTL and testbench
==============================

SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 SHALL have parameter W, default 32, meaning payload width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_vld  input  1  upstream payload valid.
REQ-005 SHALL have port in_data  input  W  upstream payload.
REQ-006 SHALL have port in_rdy  output  1  registered; block accepts in_data this cycle.
REQ-007 SHALL have port out_vld  output  1  registered; out_data valid.
REQ-008 SHALL have port out_data  output  W  registered payload to downstream.
REQ-009 SHALL have port out_rdy  input  1  downstream accepts out_data this cycle.

Function
REQ-010 SHALL transfer on the input side when in_vld && in_rdy, and on the output side when out_vld && out_rdy.
REQ-011 SHALL hold two entries: main (drives out_data) and skid (overflow), with no combinational path from out_rdy to in_rdy.
REQ-012 SHALL implement states EMPTY (no entries), ONE (main only), FULL (main + skid).
REQ-013 SHALL drive out_vld = 1 in ONE and FULL; in_rdy = 1 in EMPTY and ONE.
REQ-014 SHALL, in EMPTY with an input push, load main and go to ONE (first-word latency 1 cycle).
REQ-015 SHALL, in ONE with push and pop, load main with in_data and stay in ONE.
REQ-016 SHALL, in ONE with pop only, go to EMPTY; with push only, load skid and go to FULL.
REQ-017 SHALL, in FULL with pop, move skid into main and go to ONE; without pop, hold all state.
REQ-018 SHALL never push in FULL (in_rdy = 0); in_vld in FULL is ignored.
REQ-019 SHALL preserve strict FIFO order; no payload is dropped or duplicated.
REQ-020 SHALL keep out_data stable while out_vld && !out_rdy.
REQ-021 SHALL sustain one transfer per cycle when in_vld and out_rdy are both held high.
REQ-022 SHALL update main and skid only through enable flops whose enables derive from the state and handshake terms above.

Reset
REQ-023 SHALL, while rst_n = 0 at a clock edge, enter EMPTY: out_vld = 0, in_rdy = 1 on the following cycle.
REQ-024 SHALL discard any buffered payload on reset, including reset asserted while in ONE or FULL.
REQ-025 SHALL leave main/skid data registers unreset; out_data is don't-care while out_vld = 0.
REQ-026 SHALL ignore in_vld and out_rdy during the reset cycle.

Structure
REQ-027 SHALL place the state enumeration (EMPTY, ONE, FULL) in the shared package as a typedef.
REQ-028 SHALL instantiate the team's enable-flop primitive dffen for the main and skid data registers (two instances, width W).
REQ-029 SHALL include assertions: state encoding legal, in_vld/out_rdy/enables never X after reset, no push in FULL, out_data stable under stall.

Verification
REQ-030 SHALL cover: reset, then in_vld = 1, in_data = 0xA5 -> out_vld = 1, out_data = 0xA5 one cycle later; in_rdy = 1 throughout.
REQ-031 SHALL cover: out_rdy = 0, push 0x1 then 0x2 -> FULL, in_rdy = 0; raise out_rdy -> 0x1 then 0x2 emerge in order.
REQ-032 SHALL cover: in_vld = out_rdy = 1 for 100 cycles, incrementing data 0..99 -> 100 transfers, output in order, one per cycle after first.
REQ-033 SHALL cover: rst_n = 0 for one cycle while FULL -> next cycle out_vld = 0, in_rdy = 1, no stale payload emitted.
REQ-034 SHALL cover: random in_vld/out_rdy (50%) for 10000 cycles against scoreboard -> zero mismatches, no lost or duplicate words.
REQ-035 SHALL cover: out_rdy toggling while out_vld = 1 with 0xDEAD held -> out_data stays 0xDEAD until accepted.

Source files
------------

// File: rtl/skid_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer_pkg
// Description : Shared types and helpers for the two-entry skid buffer.
//               Holds the occupancy state enumeration and decode helpers for
//               the registered handshake flags.
// Revision    : 1.0 - initial release
// ============================================================================
package skid_buffer_pkg;

    // Occupancy of the buffer: no entries, main only, main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } sb_state_e;

    // Upstream may push whenever the skid slot is still free.
    function automatic logic sb_in_rdy(input sb_state_e s);
        return (s != ST_FULL);
    endfunction

    // Downstream sees valid data whenever main is occupied.
    function automatic logic sb_out_vld(input sb_state_e s);
        return (s != ST_EMPTY);
    endfunction

endpackage : skid_buffer_pkg
`default_nettype wire

// File: rtl/dffen.sv
`default_nettype none
// ============================================================================
// Module      : dffen
// Description : Enable flop primitive without reset. Loads d on a rising
//               clock edge when en is high, otherwise holds.
// Ports       : clk - clock
//               en  - load enable
//               d   - next value [W-1:0]
//               q   - registered value [W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module dffen #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (en) begin
            q <= d;
        end
    end

endmodule : dffen
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer
// Description : Two-entry valid/ready skid buffer. Both handshake outputs are
//               taken straight from flops, so there is no combinational path
//               from out_rdy to in_rdy. The main entry drives out_data; the
//               skid entry absorbs the word accepted in the cycle that the
//               downstream stalls.
// Ports       : clk      - clock, rising edge
//               rst_n    - synchronous active-low reset
//               in_vld   - upstream payload valid
//               in_data  - upstream payload [W-1:0]
//               in_rdy   - registered, buffer accepts in_data this cycle
//               out_vld  - registered, out_data valid
//               out_data - registered payload to downstream [W-1:0]
//               out_rdy  - downstream accepts out_data this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    input  logic         out_rdy
);

    sb_state_e    state_q;
    sb_state_e    state_d;
    logic         in_rdy_q;
    logic         in_rdy_d;
    logic         out_vld_q;
    logic         out_vld_d;
    logic         push;
    logic         pop;
    logic         main_en;
    logic         skid_en;
    logic [W-1:0] main_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    assign push = in_vld  & in_rdy_q;
    assign pop  = out_vld_q & out_rdy;

    // Next state and data-register enables. Enables are forced low during
    // reset so handshake inputs in the reset cycle have no effect.
    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;

        if (rst_n) begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        main_en = 1'b1;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_en = 1'b1;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end else if (push) begin
                        skid_en = 1'b1;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // in_rdy is low here, so only a pop can change anything.
                    if (pop) begin
                        main_en = 1'b1;
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end else begin
            state_d = ST_EMPTY;
        end

        in_rdy_d  = sb_in_rdy(state_d);
        out_vld_d = sb_out_vld(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    // Payload registers carry no reset; out_data is meaningless while
    // out_vld is low.
    dffen #(.W(W)) u_main (
        .clk (clk),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    dffen #(.W(W)) u_skid (
        .clk (clk),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

    assign in_rdy   = in_rdy_q;
    assign out_vld  = out_vld_q;
    assign out_data = main_q;

    a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
        state_q inside {ST_EMPTY, ST_ONE, ST_FULL});

    a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({in_vld, out_rdy, main_en, skid_en}));

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_FULL) |-> !push);

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_vld_q && !out_rdy) |=> (out_vld_q && $stable(main_q)));

endmodule : skid_buffer
`default_nettype wire

// File: tb/tb_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_skid_buffer
// Description : Self-checking bench for skid_buffer. Directed vector table,
//               a back-to-back streaming sequence, and a randomized run
//               compared against a bounded-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skid_buffer;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_vld;
    logic [W-1:0] in_data;
    logic         in_rdy;
    logic         out_vld;
    logic [W-1:0] out_data;
    logic         out_rdy;

    int n_total;
    int n_pass;

    skid_buffer #(.W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_rdy  (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst_n;
        logic         in_vld;
        logic [W-1:0] in_data;
        logic         out_rdy;
        logic         exp_in_rdy;
        logic         exp_out_vld;
        logic         chk_data;
        logic [W-1:0] exp_data;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic v, input logic [W-1:0] d,
                         input logic o);
        rst_n   = r;
        in_vld  = v;
        in_data = d;
        out_rdy = o;
    endtask

    // Advance one edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] model_q[$];

    initial begin
        n_total = 0;
        n_pass  = 0;
        drive(1'b0, 1'b0, '0, 1'b0);

        //         rst   vld  data        ordy  exp_rdy exp_vld chk  exp_data
        // reset, then first word with one-cycle latency
        vecs[0]  = '{1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 32'hA5,    1'b1, 1'b1, 1'b1, 1'b1, 32'hA5};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        // fill to FULL under stall, extra push ignored, drain in order
        vecs[3]  = '{1'b1, 1'b1, 32'h1,     1'b0, 1'b1, 1'b1, 1'b1, 32'h1};
        vecs[4]  = '{1'b1, 1'b1, 32'h2,     1'b0, 1'b0, 1'b1, 1'b1, 32'h1};
        vecs[5]  = '{1'b1, 1'b1, 32'h3,     1'b0, 1'b0, 1'b1, 1'b1, 32'h1};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 1'b1, 32'h2};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        // reset while FULL discards both entries
        vecs[8]  = '{1'b1, 1'b1, 32'h11,    1'b0, 1'b1, 1'b1, 1'b1, 32'h11};
        vecs[9]  = '{1'b1, 1'b1, 32'h22,    1'b0, 1'b0, 1'b1, 1'b1, 32'h11};
        vecs[10] = '{1'b0, 1'b1, 32'h33,    1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 32'h44,    1'b0, 1'b1, 1'b1, 1'b1, 32'h44};
        vecs[13] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        // 0xDEAD held through a stall with out_rdy toggling
        vecs[14] = '{1'b1, 1'b1, 32'hDEAD,  1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD};
        vecs[15] = '{1'b1, 1'b1, 32'hBEEF,  1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD};
        vecs[16] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD};
        vecs[17] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b1, 1'b1, 32'hBEEF};
        vecs[18] = '{1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 1'b1, 1'b1, 32'hBEEF};
        vecs[19] = '{1'b1, 1'b0, 32'h0,     1'b1, 1'b1, 1'b0, 1'b0, 32'h0};

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst_n, vecs[i].in_vld, vecs[i].in_data, vecs[i].out_rdy);
            tick();
            check($sformatf("vec%0d in_rdy", i), W'(in_rdy), W'(vecs[i].exp_in_rdy));
            check($sformatf("vec%0d out_vld", i), W'(out_vld), W'(vecs[i].exp_out_vld));
            if (vecs[i].chk_data)
                check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
        end

        // Streaming: one word per cycle, output trails input by one cycle.
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b1, W'(i), 1'b1);
            tick();
            check($sformatf("stream%0d in_rdy", i), W'(in_rdy), W'(1));
            check($sformatf("stream%0d out_vld", i), W'(out_vld), W'(1));
            check($sformatf("stream%0d out_data", i), out_data, W'(i));
        end
        drive(1'b1, 1'b0, '0, 1'b1);
        tick();
        check("stream drain out_vld", W'(out_vld), W'(0));

        // Randomized run against a capacity-2 FIFO model.
        drive(1'b0, 1'b0, '0, 1'b0);
        tick();
        model_q.delete();
        for (int c = 0; c < 10000; c++) begin
            logic         r, v, o, do_push, do_pop;
            logic [W-1:0] d;
            r = ($urandom_range(0, 199) != 0);
            v = 1'($urandom_range(0, 1));
            o = 1'($urandom_range(0, 1));
            d = $urandom;
            drive(r, v, d, o);
            if (!r) begin
                model_q.delete();
            end else begin
                do_push = v && (model_q.size() < 2);
                do_pop  = o && (model_q.size() > 0);
                if (do_pop)  void'(model_q.pop_front());
                if (do_push) model_q.push_back(d);
            end
            tick();
            check($sformatf("rnd%0d in_rdy", c), W'(in_rdy), W'(model_q.size() < 2));
            check($sformatf("rnd%0d out_vld", c), W'(out_vld), W'(model_q.size() > 0));
            if (model_q.size() > 0)
                check($sformatf("rnd%0d out_data", c), out_data, model_q[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_skid_buffer
`default_nettype wire
